npc_ras_unit: RTL and testbench

Parametrised next-generation next-PC block for the fetch stage. It owns the architectural PC register and computes the next PC for sequential, beq/bne, j/jal and jr flow. It also supports stall, exception redirect and a circular return-address stack (RAS). The RAS output is advisory: the pipelined fetch predictor consumes it later, and jr always redirects to the `target` input.

---
 rtl/npc_ras_unit.sv | 128 ++++++++++++
 tb/tb_npc_ras_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_ras_unit.sv
// npc_ras_unit: fetch-stage next-PC generator.
// Owns the architectural PC. Selects the next PC for sequential, beq/bne,
// j/jal and jr flow, and handles stall and exception redirect.
// A small circular return-address stack is advisory only: jr always
// redirects to the target operand.
module npc_ras_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4,
  parameter bit          BNE_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        exc,
  input  logic [2:0]  NpcSel,
  input  logic        zero,
  input  logic [25:0] imm,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pcp4,
  output logic [31:0] npc,
  output logic [31:0] ras_top,
  output logic        ras_empty,
  output logic        ras_full,
  output logic        ras_hit
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BEQ = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JAL = 3'b011;
  localparam logic [2:0] SEL_JR  = 3'b100;
  localparam logic [2:0] SEL_BNE = 3'b101;

  logic [31:0]   pc_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wptr_reg;
  logic [31:0]   ras_mem [RAS_DEPTH];

  logic [31:0]   br_off;
  logic [31:0]   jr_addr;
  logic [PW-1:0] top_ptr;
  logic          upd_en;
  logic          push;
  logic          pop;

  assign pc      = pc_reg;
  assign pcp4    = pc_reg + 32'd4;
  assign br_off  = {{14{imm[15]}}, imm[15:0], 2'b00};
  assign jr_addr = {target[31:2], 2'b00};

  // The newest entry sits just below the write pointer; wraps naturally.
  assign top_ptr   = wptr_reg - 1'b1;
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CW'(RAS_DEPTH));
  assign ras_top   = ras_empty ? 32'd0 : ras_mem[top_ptr];
  assign ras_hit   = (NpcSel == SEL_JR) && !ras_empty && (ras_top == jr_addr);

  // RAS only moves in cycles that actually retire a fetch decision.
  assign upd_en = !stall && !exc;
  assign push   = upd_en && (NpcSel == SEL_JAL);
  assign pop    = upd_en && (NpcSel == SEL_JR) && !ras_empty;

  // Next-PC priority mux; unused select codes fall through to sequential.
  always_comb begin
    npc = pcp4;
    if (exc) begin
      npc = EXC_VEC;
    end else if (NpcSel == SEL_BEQ && zero) begin
      npc = pcp4 + br_off;
    end else if (BNE_EN && NpcSel == SEL_BNE && !zero) begin
      npc = pcp4 + br_off;
    end else if (NpcSel == SEL_J || NpcSel == SEL_JAL) begin
      npc = {pcp4[31:28], imm, 2'b00};
    end else if (NpcSel == SEL_JR) begin
      npc = jr_addr;
    end else begin
      npc = pcp4;
    end
  end

  // PC register: exception wins over stall, otherwise load npc unless stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
    end else if (exc) begin
      pc_reg <= EXC_VEC;
    end else if (!stall) begin
      pc_reg <= npc;
    end
  end

  // RAS pointer and occupancy; a push when full overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_reg  <= '0;
      count_reg <= '0;
    end else if (push) begin
      wptr_reg <= wptr_reg + 1'b1;
      if (!ras_full) begin
        count_reg <= count_reg + 1'b1;
      end
    end else if (pop) begin
      wptr_reg  <= wptr_reg - 1'b1;
      count_reg <= count_reg - 1'b1;
    end
  end

  // One register per RAS slot, written when the pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
      // Capture the return address into this slot on a push.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ras_mem[gi] <= 32'd0;
        end else if (push && (wptr_reg == PW'(gi))) begin
          ras_mem[gi] <= pcp4;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_npc_ras_unit.sv
// tb_npc_ras_unit: directed bench for npc_ras_unit with a scoreboard queue.
// Expectations are queued as stimulus is applied and popped at sample points.
module tb_npc_ras_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        exc;
  logic [2:0]  NpcSel;
  logic        zero;
  logic [25:0] imm;
  logic [31:0] target;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic [31:0] npc;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_hit;

  int n_asserts = 0;
  int n_fails   = 0;

  string       tag_q [$];
  int          sel_q [$];
  logic [31:0] exp_q [$];

  localparam int S_PC = 0, S_PCP4 = 1, S_NPC = 2, S_TOP = 3, S_EMPTY = 4, S_FULL = 5, S_HIT = 6;

  npc_ras_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .exc(exc), .NpcSel(NpcSel),
    .zero(zero), .imm(imm), .target(target), .pc(pc), .pcp4(pcp4), .npc(npc),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full), .ras_hit(ras_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_PC:    return pc;
      S_PCP4:  return pcp4;
      S_NPC:   return npc;
      S_TOP:   return ras_top;
      S_EMPTY: return {31'd0, ras_empty};
      S_FULL:  return {31'd0, ras_full};
      default: return {31'd0, ras_hit};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(val);
  endtask

  // Pop every queued expectation and compare against the live DUT outputs.
  task automatic drain();
    string       t;
    int          s;
    logic [31:0] e;
    logic [31:0] o;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      o = observe(s);
      n_asserts++;
      assert (o === e) else begin
        n_fails++;
        $error("FAIL %s: observed %h expected %h", t, o, e);
      end
      $display("check %-14s observed %h expected %h", t, o, e);
    end
  endtask

  // Advance one clock and settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic z, input logic [25:0] im,
                       input logic [31:0] tg, input logic st, input logic ex);
    NpcSel = sel; zero = z; imm = im; target = tg; stall = st; exc = ex;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(3'b000, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(3'b000, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Reset state
    expect_val("rst_pc", S_PC, 32'h3000);
    expect_val("rst_pcp4", S_PCP4, 32'h3004);
    expect_val("rst_empty", S_EMPTY, 32'd1);
    expect_val("rst_full", S_FULL, 32'd0);
    expect_val("rst_top", S_TOP, 32'd0);
    expect_val("rst_hit", S_HIT, 32'd0);
    drain();

    // Sequential flow
    tick();
    expect_val("seq_pc1", S_PC, 32'h3004);
    drain();

    // Branch decode at pc=0x3004, offset -1 word
    drive(3'b001, 1'b1, 26'h000FFFF, 32'd0, 1'b0, 1'b0);
    expect_val("beq_taken", S_NPC, 32'h3004);
    drain();
    drive(3'b001, 1'b0, 26'h000FFFF, 32'd0, 1'b0, 1'b0);
    expect_val("beq_untaken", S_NPC, 32'h3008);
    drain();
    drive(3'b101, 1'b0, 26'h000FFFF, 32'd0, 1'b0, 1'b0);
    expect_val("bne_taken", S_NPC, 32'h3004);
    drain();
    drive(3'b101, 1'b1, 26'h000FFFF, 32'd0, 1'b0, 1'b0);
    expect_val("bne_untaken", S_NPC, 32'h3008);
    drain();
    drive(3'b110, 1'b1, 26'h000FFFF, 32'h1234, 1'b0, 1'b0);
    expect_val("sel110_seq", S_NPC, 32'h3008);
    drain();
    drive(3'b000, 1'b0, 26'd0, 32'd0, 1'b0, 1'b0);
    tick();
    expect_val("seq_pc2", S_PC, 32'h3008);
    expect_val("seq_empty", S_EMPTY, 32'd1);
    drain();

    // j / jal self-loop / jr with hit
    do_reset();
    drive(3'b010, 1'b0, 26'h0000C10, 32'd0, 1'b0, 1'b0);
    expect_val("j_npc", S_NPC, 32'h3040);
    drain();
    tick();
    expect_val("j_pc", S_PC, 32'h3040);
    drain();
    drive(3'b011, 1'b0, 26'h0000C10, 32'd0, 1'b0, 1'b0);
    tick();
    expect_val("jal_pc", S_PC, 32'h3040);
    expect_val("jal_top", S_TOP, 32'h3044);
    expect_val("jal_empty", S_EMPTY, 32'd0);
    drain();
    drive(3'b100, 1'b0, 26'd0, 32'h3047, 1'b0, 1'b0);
    expect_val("jr_hit", S_HIT, 32'd1);
    expect_val("jr_npc", S_NPC, 32'h3044);
    drain();
    tick();
    expect_val("jr_pc", S_PC, 32'h3044);
    expect_val("jr_empty", S_EMPTY, 32'd1);
    expect_val("jr_top", S_TOP, 32'd0);
    drain();

    // Five jal pushes into a 4-deep RAS
    do_reset();
    drive(3'b011, 1'b0, 26'h0000C04, 32'd0, 1'b0, 1'b0); tick();
    drive(3'b011, 1'b0, 26'h0000C08, 32'd0, 1'b0, 1'b0); tick();
    drive(3'b011, 1'b0, 26'h0000C0C, 32'd0, 1'b0, 1'b0); tick();
    expect_val("push3_full", S_FULL, 32'd0);
    drain();
    drive(3'b011, 1'b0, 26'h0000C10, 32'd0, 1'b0, 1'b0); tick();
    expect_val("push4_full", S_FULL, 32'd1);
    expect_val("push4_pc", S_PC, 32'h3040);
    drain();
    drive(3'b011, 1'b0, 26'h0000C14, 32'd0, 1'b0, 1'b0); tick();
    expect_val("push5_full", S_FULL, 32'd1);
    expect_val("push5_top", S_TOP, 32'h3044);
    drain();

    // Pops: tops 3044, 3034, 3024, 3014, then empty
    drive(3'b100, 1'b0, 26'd0, 32'h3100, 1'b0, 1'b0);
    expect_val("pop1_top", S_TOP, 32'h3044);
    expect_val("pop1_nohit", S_HIT, 32'd0);
    drain();
    tick();
    expect_val("pop2_top", S_TOP, 32'h3034);
    expect_val("pop1_pc", S_PC, 32'h3100);
    expect_val("pop1_full", S_FULL, 32'd0);
    drain();
    tick();
    expect_val("pop3_top", S_TOP, 32'h3024);
    drain();
    drive(3'b100, 1'b0, 26'd0, 32'h3016, 1'b0, 1'b0);
    tick();
    expect_val("pop4_top", S_TOP, 32'h3014);
    expect_val("pop4_hit", S_HIT, 32'd1);
    drain();
    tick();
    expect_val("pop4_empty", S_EMPTY, 32'd1);
    expect_val("pop4_ztop", S_TOP, 32'd0);
    drain();
    drive(3'b100, 1'b0, 26'd0, 32'h3204, 1'b0, 1'b0);
    tick();
    expect_val("under_pc", S_PC, 32'h3204);
    expect_val("under_empty", S_EMPTY, 32'd1);
    expect_val("under_full", S_FULL, 32'd0);
    drain();

    // Stall holds PC and RAS
    drive(3'b011, 1'b0, 26'h0000C00, 32'd0, 1'b0, 1'b0);
    tick();
    expect_val("pre_stall_top", S_TOP, 32'h3208);
    expect_val("pre_stall_pc", S_PC, 32'h3000);
    drain();
    drive(3'b011, 1'b0, 26'h0000C20, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    expect_val("stall_pc", S_PC, 32'h3000);
    expect_val("stall_top", S_TOP, 32'h3208);
    expect_val("stall_full", S_FULL, 32'd0);
    expect_val("stall_npc", S_NPC, 32'h3080);
    drain();

    // Exception overrides stall; RAS untouched
    drive(3'b011, 1'b0, 26'h0000C20, 32'd0, 1'b1, 1'b1);
    expect_val("exc_npc", S_NPC, 32'h4180);
    drain();
    tick();
    expect_val("exc_pc", S_PC, 32'h4180);
    expect_val("exc_top", S_TOP, 32'h3208);
    drain();
    drive(3'b100, 1'b0, 26'd0, 32'h3208, 1'b0, 1'b1);
    tick();
    expect_val("exc_jr_pc", S_PC, 32'h4180);
    expect_val("exc_jr_top", S_TOP, 32'h3208);
    expect_val("exc_jr_empty", S_EMPTY, 32'd0);
    drain();

    // Async reset mid-cycle after two pushes
    drive(3'b011, 1'b0, 26'h0000C00, 32'd0, 1'b0, 1'b0); tick();
    drive(3'b011, 1'b0, 26'h0000C00, 32'd0, 1'b0, 1'b0); tick();
    expect_val("mid_top", S_TOP, 32'h3004);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("arst_pc", S_PC, 32'h3000);
    expect_val("arst_empty", S_EMPTY, 32'd1);
    expect_val("arst_top", S_TOP, 32'd0);
    drain();
    #3;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
